// File: rtl/scanout_pkg.sv
// Shared types and helpers for the bram_scanout framebuffer scan-out stage.
package scanout_pkg;

  typedef logic [23:0] rgb24_t;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StActive,
    StDone
  } line_state_e;

  // Bit n set means a replication factor of n is supported.
  localparam logic [31:0] ScaleLegalMask = 32'h0000_0110;

  function automatic logic scale_is_legal(input int unsigned s);
    logic legal;
    legal = 1'b0;
    if (s < 32) legal = ScaleLegalMask[s];
    return legal;
  endfunction

  function automatic rgb24_t rgb332_expand(input logic [7:0] c);
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
    r = c[7:5];
    g = c[4:2];
    b = c[1:0];
    return {r, r, r[2:1], g, g, g[2:1], b, b, b, b};
  endfunction

endpackage

// File: rtl/bram_scanout_if.sv
// Video strobe, pixel and host write bus for bram_scanout.
interface bram_scanout_if
  import scanout_pkg::*;
#(
  parameter int unsigned ADDR_W = 15
);
  logic              i_newframe;
  logic              i_newline;
  logic              i_enable;
  rgb24_t            pixel;
  logic              o_underrun;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              pal_we;
  logic [7:0]        pal_addr;
  rgb24_t            pal_data;

  modport master (
    output i_newframe, i_newline, i_enable,
    output wr_en, wr_addr, wr_data, pal_we, pal_addr, pal_data,
    input  pixel, o_underrun
  );

  modport slave (
    input  i_newframe, i_newline, i_enable,
    input  wr_en, wr_addr, wr_data, pal_we, pal_addr, pal_data,
    output pixel, o_underrun
  );
endinterface

// File: rtl/scanout_fb_ram.sv
// Simple dual-port synchronous RAM; a read colliding with a write returns the old word.
module scanout_fb_ram #(
  parameter int unsigned Depth = 256,
  parameter int unsigned Width = 8,
  parameter int unsigned AddrW = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic             re,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);
  localparam logic [AddrW:0] DepthW = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem [Depth];

  // Out-of-range writes are dropped rather than aliased.
  always_ff @(posedge clk) begin
    if (we && ({1'b0, waddr} < DepthW)) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= ({1'b0, raddr} < DepthW) ? mem[raddr] : '0;
    end
  end
endmodule

// File: rtl/bram_scanout.sv
// Framebuffer scan-out: replays an 8 bpp BRAM image upscaled by SCALE on the pixel strobes.
// Define PALETTE_EN to treat framebuffer bytes as indices into a 256x24 palette RAM.
module bram_scanout
  import scanout_pkg::*;
#(
  parameter int unsigned H_SRC  = 160,
  parameter int unsigned V_SRC  = 120,
  parameter int unsigned SCALE  = 4,
  parameter int unsigned ADDR_W = 15
) (
  input logic           clk,
  input logic           rst,
  bram_scanout_if.slave bus
);
  localparam int unsigned FbDepth = H_SRC * V_SRC;
  localparam int unsigned SubW    = $clog2(SCALE);
  localparam int unsigned SxW     = $clog2(H_SRC + 1);
  localparam int unsigned SyW     = $clog2(V_SRC + 1);
  localparam logic [SubW-1:0] SubLast = SubW'(SCALE - 1);
  localparam logic [SxW-1:0]  SxLast  = SxW'(H_SRC - 1);
`ifdef PALETTE_EN
  localparam logic PrimeLast = 1'b1;
`else
  localparam logic PrimeLast = 1'b0;
`endif

  if (!scale_is_legal(SCALE)) begin : g_bad_scale
    $error("bram_scanout: SCALE must be 4 or 8");
  end

  // Row tracking
  logic [SyW-1:0]    sy_q;
  logic [SubW-1:0]   sub_y_q;
  logic [ADDR_W-1:0] row_acc_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              row_valid;

  assign row_valid = (sy_q < SyW'(V_SRC));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sy_q       <= '0;
      sub_y_q    <= '0;
      row_acc_q  <= '0;
      row_base_q <= '0;
    end else if (bus.i_newframe) begin
      sy_q      <= '0;
      sub_y_q   <= '0;
      row_acc_q <= '0;
    end else if (bus.i_newline) begin
      row_base_q <= row_acc_q;
      if (row_valid) begin
        if (sub_y_q == SubLast) begin
          sub_y_q   <= '0;
          sy_q      <= sy_q + 1'b1;
          row_acc_q <= row_acc_q + ADDR_W'(H_SRC);
        end else begin
          sub_y_q <= sub_y_q + 1'b1;
        end
      end
    end
  end

  // Line FSM state
  line_state_e     state_q;
  logic [SxW-1:0]  sx_q;
  logic [SubW-1:0] sx_sub_q;
  logic            prime_q;
  rgb24_t          hold_q;
  logic            underrun_q;

  // Framebuffer read port: first pixel on newline, then one prefetch per source pixel.
  logic              fb_re;
  logic [ADDR_W-1:0] fb_raddr;
  logic [7:0]        fb_q;
  rgb24_t            colour;

  always_comb begin
    fb_re    = 1'b0;
    fb_raddr = row_acc_q;
    if (bus.i_newframe) begin
      fb_re = 1'b0;
    end else if (bus.i_newline) begin
      fb_re = row_valid;
    end else if (state_q == StActive && bus.i_enable && sx_sub_q == '0) begin
      fb_re    = 1'b1;
      fb_raddr = row_base_q + ADDR_W'(sx_q) + ADDR_W'(1);
    end
  end

  scanout_fb_ram #(
    .Depth(FbDepth),
    .Width(8),
    .AddrW(ADDR_W)
  ) u_fb (
    .clk  (clk),
    .we   (bus.wr_en),
    .waddr(bus.wr_addr),
    .wdata(bus.wr_data),
    .re   (fb_re),
    .raddr(fb_raddr),
    .rdata(fb_q)
  );

`ifdef PALETTE_EN
  rgb24_t pal_q;

  scanout_fb_ram #(
    .Depth(256),
    .Width(24),
    .AddrW(8)
  ) u_pal (
    .clk  (clk),
    .we   (bus.pal_we),
    .waddr(bus.pal_addr),
    .wdata(bus.pal_data),
    .re   (1'b1),
    .raddr(fb_q),
    .rdata(pal_q)
  );

  assign colour = pal_q;
`else
  logic unused_pal;
  assign unused_pal = ^{bus.pal_we, bus.pal_addr, bus.pal_data};
  assign colour     = rgb332_expand(fb_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      sx_q       <= '0;
      sx_sub_q   <= '0;
      prime_q    <= 1'b0;
      hold_q     <= '0;
      underrun_q <= 1'b0;
    end else if (bus.i_newframe) begin
      state_q  <= StIdle;
      sx_q     <= '0;
      sx_sub_q <= '0;
      prime_q  <= 1'b0;
      hold_q   <= '0;
    end else if (bus.i_newline) begin
      sx_q     <= '0;
      sx_sub_q <= '0;
      prime_q  <= 1'b0;
      hold_q   <= '0;
      if (row_valid) begin
        state_q <= StPrime;
      end else begin
        // Line below the scaled image: stay black and flag it.
        state_q    <= StDone;
        underrun_q <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          hold_q <= '0;
        end
        StPrime: begin
          if (bus.i_enable) underrun_q <= 1'b1;
          if (prime_q == PrimeLast) begin
            hold_q  <= colour;
            state_q <= StActive;
          end else begin
            prime_q <= 1'b1;
          end
        end
        StActive: begin
          if (bus.i_enable) begin
            if (sx_sub_q == SubLast) begin
              sx_sub_q <= '0;
              if (sx_q == SxLast) begin
                state_q <= StDone;
                hold_q  <= '0;
              end else begin
                sx_q   <= sx_q + 1'b1;
                hold_q <= colour;
              end
            end else begin
              sx_sub_q <= sx_sub_q + 1'b1;
            end
          end
        end
        StDone: begin
          if (bus.i_enable) underrun_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pixel      = hold_q;
  assign bus.o_underrun = underrun_q;
endmodule

// File: tb/tb_bram_scanout.sv
// Directed self-checking bench for bram_scanout (default SCALE=4, 160x120 source).
module tb_bram_scanout;
  localparam int unsigned HSrc  = 160;
  localparam int unsigned VSrc  = 120;
  localparam int unsigned Scale = 4;
  localparam int unsigned AddrW = 15;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  bram_scanout_if #(.ADDR_W(AddrW)) bus_if ();

  bram_scanout #(
    .H_SRC (HSrc),
    .V_SRC (VSrc),
    .SCALE (Scale),
    .ADDR_W(AddrW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] exp332(input logic [7:0] c);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = {c[7:5], c[7:5], c[7:6]};
    g = {c[4:2], c[4:2], c[4:3]};
    b = {c[1:0], c[1:0], c[1:0], c[1:0]};
    return {r, g, b};
  endfunction

  function automatic logic [7:0] grad(input int x, input int y);
    return 8'((x * 3 + y * 7) & 255);
  endfunction

  // Inputs change on the falling edge; outputs sampled there too.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_if.i_newframe = 1'b0;
    bus_if.i_newline  = 1'b0;
    bus_if.i_enable   = 1'b0;
    bus_if.wr_en      = 1'b0;
    bus_if.wr_addr    = '0;
    bus_if.wr_data    = '0;
    bus_if.pal_we     = 1'b0;
    bus_if.pal_addr   = '0;
    bus_if.pal_data   = '0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic fb_write(input int addr, input logic [7:0] data);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = AddrW'(addr);
    bus_if.wr_data = data;
    tick();
    bus_if.wr_en = 1'b0;
  endtask

  task automatic pulse_newframe();
    bus_if.i_newframe = 1'b1;
    tick();
    bus_if.i_newframe = 1'b0;
  endtask

  // Newline followed by the minimum 3-cycle lead before enables.
  task automatic pulse_newline(input int lead);
    bus_if.i_newline = 1'b1;
    tick();
    bus_if.i_newline = 1'b0;
    repeat (lead) tick();
  endtask

  task automatic test_reset();
    tick();
    idle_inputs();
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus_if.pixel !== 24'h0 || bus_if.o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: pixel=%h underrun=%b want 000000/0", bus_if.pixel,
               bus_if.o_underrun);
    end
    rst = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c % 10 == 9) begin
        checks++;
        if (bus_if.pixel !== 24'h0 || bus_if.o_underrun !== 1'b0) begin
          errors++;
          $display("FAIL reset_idle cyc%0d: pixel=%h underrun=%b want 000000/0", c,
                   bus_if.pixel, bus_if.o_underrun);
        end
      end
    end
  endtask

  task automatic test_basic();
    logic [23:0] want;
    do_reset();
    fb_write(0, 8'hE0);
    fb_write(1, 8'h1C);
    pulse_newframe();
    pulse_newline(3);
    for (int e = 0; e < 641; e++) begin
      bus_if.i_enable = 1'b1;
      if (e < 8 || e == 640) begin
        want = (e < 4) ? 24'hFF0000 : (e < 8) ? 24'h00FF00 : 24'h000000;
        checks++;
        if (bus_if.pixel !== want) begin
          errors++;
          $display("FAIL basic enable%0d: pixel=%h want %h", e, bus_if.pixel, want);
        end
      end
      if (e == 639) begin
        checks++;
        if (bus_if.o_underrun !== 1'b0) begin
          errors++;
          $display("FAIL basic underrun_early: got %b want 0", bus_if.o_underrun);
        end
      end
      tick();
    end
    bus_if.i_enable = 1'b0;
    tick();
    checks++;
    if (bus_if.o_underrun !== 1'b1) begin
      errors++;
      $display("FAIL basic underrun_641: got %b want 1", bus_if.o_underrun);
    end
  endtask

  task automatic test_restart();
    logic [23:0] want;
    do_reset();
    pulse_newframe();
    pulse_newline(3);
    repeat (6) begin
      bus_if.i_enable = 1'b1;
      tick();
    end
    bus_if.i_enable = 1'b0;
    pulse_newline(3);
    for (int e = 0; e < 5; e++) begin
      bus_if.i_enable = 1'b1;
      want = (e < 4) ? 24'hFF0000 : 24'h00FF00;
      checks++;
      if (bus_if.pixel !== want) begin
        errors++;
        $display("FAIL restart enable%0d: pixel=%h want %h", e, bus_if.pixel, want);
      end
      tick();
    end
    bus_if.i_enable = 1'b0;
  endtask

  task automatic test_gapped();
    logic [23:0] want [4];
    want[0] = 24'hFF0000;
    want[1] = 24'h00FF00;
    want[2] = 24'h0000FF;
    want[3] = 24'hFFFFFF;
    do_reset();
    fb_write(0, 8'hE0);
    fb_write(1, 8'h1C);
    fb_write(2, 8'h03);
    fb_write(3, 8'hFF);
    pulse_newframe();
    pulse_newline(3);
    for (int e = 0; e < 16; e++) begin
      bus_if.i_enable = 1'b1;
      checks++;
      if (bus_if.pixel !== want[e / 4]) begin
        errors++;
        $display("FAIL gapped enable%0d: pixel=%h want %h", e, bus_if.pixel, want[e / 4]);
      end
      tick();
      bus_if.i_enable = 1'b0;
      tick();
    end
  endtask

  task automatic test_early_enable();
    do_reset();
    pulse_newframe();
    bus_if.i_newline = 1'b1;
    tick();
    bus_if.i_newline = 1'b0;
    bus_if.i_enable  = 1'b1;
    checks++;
    if (bus_if.pixel !== 24'h0) begin
      errors++;
      $display("FAIL early_pixel: pixel=%h want 000000", bus_if.pixel);
    end
    tick();
    bus_if.i_enable = 1'b0;
    checks++;
    if (bus_if.o_underrun !== 1'b1) begin
      errors++;
      $display("FAIL early_underrun: got %b want 1", bus_if.o_underrun);
    end
  endtask

  task automatic test_frame();
    logic [23:0] want;
    int          bad;
    do_reset();
    for (int a = 0; a < int'(HSrc * VSrc); a++) begin
      bus_if.wr_en   = 1'b1;
      bus_if.wr_addr = AddrW'(a);
      bus_if.wr_data = grad(a % HSrc, a / HSrc);
      tick();
    end
    bus_if.wr_en = 1'b0;
    pulse_newframe();
    for (int line = 0; line < int'(VSrc * Scale); line++) begin
      if (line < 8 || line >= 472) begin
        pulse_newline(3);
        bad = 0;
        for (int e = 0; e < int'(HSrc * Scale); e++) begin
          bus_if.i_enable = 1'b1;
          want = exp332(grad(e / Scale, line / Scale));
          if (bus_if.pixel !== want && bad == 0) begin
            bad = 1;
            $display("FAIL frame line%0d enable%0d: pixel=%h want %h", line, e, bus_if.pixel,
                     want);
          end
          tick();
        end
        bus_if.i_enable = 1'b0;
        checks++;
        if (bad != 0) errors++;
      end else begin
        pulse_newline(2);
      end
    end
    tick();
    checks++;
    if (bus_if.o_underrun !== 1'b0) begin
      errors++;
      $display("FAIL frame_underrun: got %b want 0", bus_if.o_underrun);
    end
    // One line past the scaled image height.
    pulse_newline(3);
    bus_if.i_enable = 1'b1;
    checks++;
    if (bus_if.pixel !== 24'h0) begin
      errors++;
      $display("FAIL frame_extra_pixel: pixel=%h want 000000", bus_if.pixel);
    end
    tick();
    bus_if.i_enable = 1'b0;
    checks++;
    if (bus_if.o_underrun !== 1'b1) begin
      errors++;
      $display("FAIL frame_extra_underrun: got %b want 1", bus_if.o_underrun);
    end
  endtask

`ifdef PALETTE_EN
  task automatic test_palette();
    do_reset();
    bus_if.pal_we   = 1'b1;
    bus_if.pal_addr = 8'd5;
    bus_if.pal_data = 24'h123456;
    tick();
    bus_if.pal_we = 1'b0;
    fb_write(0, 8'd5);
    pulse_newframe();
    pulse_newline(3);
    for (int e = 0; e < 4; e++) begin
      bus_if.i_enable = 1'b1;
      checks++;
      if (bus_if.pixel !== 24'h123456) begin
        errors++;
        $display("FAIL palette enable%0d: pixel=%h want 123456", e, bus_if.pixel);
      end
      tick();
    end
    bus_if.i_enable = 1'b0;
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();
    test_reset();
`ifdef PALETTE_EN
    test_palette();
    test_early_enable();
`else
    test_basic();
    test_restart();
    test_gapped();
    test_early_enable();
    test_frame();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bram_scanout.md
# bram_scanout

Framebuffer scan-out stage feeding the HDMI transmitter's pixel inputs. It holds a low-resolution 8 bpp image in block RAM, written by a simple host port. It replays the image upscaled by an integer factor, stepping on the transmitter's newframe/newline/enable strobes, and emits the 24-bit pixel for the current active position. All logic runs on the single pixel-rate clock that also drives the transmitter's strobes.

## Interface
Parameters:
- H_SRC, 160: source image width in pixels.
- V_SRC, 120: source image height in lines.
- SCALE, 4: horizontal and vertical replication factor; legal values 4 or 8.
- ADDR_W, 15: framebuffer address width; must satisfy 2**ADDR_W ≥ H_SRC*V_SRC.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  reset, asynchronous, active-low.
- i_newframe  in  1  one-cycle pulse before the first active line of a frame.
- i_newline  in  1  one-cycle pulse before each active line; precedes that line's first i_enable by ≥3 cycles.
- i_enable  in  1  the pixel on `pixel` is consumed this cycle.
- pixel  out  24  {R,G,B}, 8 bits each.
- wr_en  in  1  framebuffer write strobe.
- wr_addr  in  ADDR_W  framebuffer write address, y*H_SRC+x.
- wr_data  in  8  framebuffer write data.
- pal_we  in  1  palette write strobe; ignored without PALETTE_EN.
- pal_addr  in  8  palette entry index.
- pal_data  in  24  palette entry value.
- o_underrun  out  1  sticky error flag.

## Operation
- Framebuffer: one BRAM of H_SRC*V_SRC×8 with a synchronous read of latency 1.
  - On a same-cycle read/write to the same address, the read returns the old data.
  - Writes with wr_addr ≥ H_SRC*V_SRC are dropped.
- Row tracking:
  - i_newframe sets sy=0 and sub_y=0.
  - Each i_newline latches row_base=sy*H_SRC, then advances sub_y. When sub_y wraps at SCALE, it advances sy.
  - row_base is kept incrementally by adding H_SRC; there is no multiplier.
  - Lines beyond V_SRC*SCALE in a frame output black and set o_underrun.
- Line FSM states: IDLE, PRIME, ACTIVE, DONE.
  - IDLE→PRIME on i_newline: issue a read of row_base+0.
  - PRIME→ACTIVE once the colour is loaded into the hold register, 2 cycles with PALETTE_EN, 1 without.
  - In ACTIVE, a sub-counter sx_sub counts i_enable cycles.
    - When sx_sub==0, prefetch source pixel sx+1.
    - When sx_sub==SCALE-1, load the prefetched colour into hold and increment sx.
  - After H_SRC*SCALE enables, go to DONE. Further i_enable in DONE keeps pixel=0 and sets o_underrun.
  - i_newline in any state restarts at PRIME. i_newframe in any state resets the row tracking and returns to IDLE.
- Output: pixel is the hold register, which is 0 in IDLE and DONE.
- Early enable: i_enable while in PRIME sets o_underrun; pixel stays 0 for that cycle.
- o_underrun clears only on reset.

## Timing
- Reset: pixel=0, o_underrun=0, FSM=IDLE, all counters 0. Palette and framebuffer contents are not reset.
- After a change, pixel holds a source colour for exactly SCALE i_enable cycles, even when enables are gapped.
- For back-to-back enables, prefetch lead is SCALE-1 cycles, which is at least the 2-cycle read+palette latency.
- A framebuffer write becomes visible if it lands ≥1 cycle before that pixel's prefetch read.

## Configuration
- PALETTE_EN defined:
  - wr_data is a palette index into a 256×24 BRAM, written via pal_we/pal_addr/pal_data.
  - This adds 1 cycle of read latency.
  - The palette is not initialised; its contents are undefined until written.
- PALETTE_EN undefined:
  - wr_data is RGB332, expanded combinationally as R={r,r,r[2:1]}, G={g,g,g[2:1]}, B={b,b,b,b}.
  - The pal_* ports are ignored.

## Structure
- Package scanout_pkg: rgb24_t typedef, the rgb332_expand function, line FSM state enum, SCALE legality constant.
- Sub-module scanout_fb_ram: dual-port (write/read) synchronous BRAM with the old-data read-during-write rule.
  - Instantiated once for the framebuffer.
  - Instantiated a second time for the palette under PALETTE_EN.

## Test plan
- Reset, no strobes → pixel=0, o_underrun=0 for 100 cycles.
- No PALETTE_EN; write 0xE0 at address 0, 0x1C at 1; newframe, newline, 8 enables → 4×0xFFFF00? No: 0xE0 → 4×0xFF0000, then 0x1C → 4×0x00FF00.
- Full 160×120 gradient at SCALE=4; drive 480 lines of 640 enables → each source row appears on 4 consecutive lines, and o_underrun stays 0.
- Gapped enables, one idle cycle between each → every colour still lasts exactly 4 enables.
- Overflow cases:
  - i_enable one cycle after i_newline → o_underrun=1, first pixel=0.
  - 641st enable in a line → pixel=0.
- PALETTE_EN: palette[5]=0x123456, fb[0]=5 → first 4 enables of line 0 output 0x123456.
